// File: rtl/systolic_ctrl_pkg.sv
// Shared encodings and array-dimension defines for the systolic array control blocks.
`ifndef SYSTOLIC_ROWS
`define SYSTOLIC_ROWS 4
`endif
`ifndef SYSTOLIC_COLS
`define SYSTOLIC_COLS 4
`endif

package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitOut,
        StDrain,
        StDone,
        StAbort
    } arb_state_e;

    typedef enum logic {
        OWN_MM   = 1'b0,
        OWN_BIST = 1'b1
    } owner_e;

endpackage

// File: rtl/job_priority_sel.sv
// Matmul-first winner selection with a starvation guard for pending BIST requests.
module job_priority_sel #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mm_valid,
    input  logic bist_valid,
    input  logic grant_en,
    output logic grant_mm,
    output logic grant_bist
);

    localparam int unsigned DW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [DW-1:0] Limit = DW'(STARVE_LIMIT);

    logic [DW-1:0] defer_q, defer_d;

    always_comb begin
        grant_mm   = 1'b0;
        grant_bist = 1'b0;
        if (grant_en) begin
            if (mm_valid && !(bist_valid && (defer_q == Limit))) begin
                grant_mm = 1'b1;
            end else if (bist_valid) begin
                grant_bist = 1'b1;
            end
        end
    end

    // Counts matmul wins taken over a waiting BIST request; saturates at the limit.
    always_comb begin
        defer_d = defer_q;
        if (grant_bist) begin
            defer_d = '0;
        end else if (grant_mm && bist_valid && (defer_q != Limit)) begin
            defer_d = defer_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Arbitrates matmul and BIST jobs onto one systolic array and supervises each job
// through start, output wait and drain, aborting a phase that exceeds TIMEOUT cycles.
module systolic_job_arbiter
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned ROWS         = `SYSTOLIC_ROWS,
    parameter int unsigned COLS         = `SYSTOLIC_COLS,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mm_valid,
    output logic            mm_ready,
    input  logic            bist_valid,
    output logic            bist_ready,
    output logic            start_fsm,
    output logic            bist_mode,
    input  logic [COLS-1:0] output_col_valid,
    output logic            array_rst,
    output logic            busy,
    output logic            done,
    output logic            done_owner,
    output logic            err
);

    localparam int unsigned PW = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] PhaseLast = PW'(TIMEOUT - 1);

    if (ROWS == 0 || COLS == 0 || TIMEOUT == 0) begin : g_bad_params
        $error("systolic_job_arbiter: ROWS, COLS and TIMEOUT must be nonzero");
    end

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [PW-1:0] phase_q, phase_d, phase_inc;
    logic          seen_q, seen_d;
    logic          grant_en, grant_mm, grant_bist, col_any, timeout;

    assign grant_en  = (state_q == StIdle) && !rst;
    assign col_any   = |output_col_valid;
    assign timeout   = (phase_q == PhaseLast);
    assign phase_inc = timeout ? phase_q : phase_q + PW'(1);

    job_priority_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .mm_valid  (mm_valid),
        .bist_valid(bist_valid),
        .grant_en  (grant_en),
        .grant_mm  (grant_mm),
        .grant_bist(grant_bist)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_MM;
            phase_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            phase_q <= phase_d;
            seen_q  <= seen_d;
        end
    end

    // Phase counter reads 0 in START and on DRAIN entry, so abort lands TIMEOUT cycles later.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        phase_d = phase_q;
        seen_d  = seen_q;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                seen_d  = 1'b0;
                if (grant_mm) begin
                    owner_d = OWN_MM;
                    state_d = StStart;
                end else if (grant_bist) begin
                    owner_d = OWN_BIST;
                    state_d = StStart;
                end
            end
            StStart: begin
                phase_d = phase_inc;
                seen_d  = col_any;
                state_d = StWaitOut;
            end
            StWaitOut: begin
                if (col_any || seen_q) begin
                    phase_d = '0;
                    state_d = StDrain;
                end else if (timeout) begin
                    state_d = StAbort;
                end else begin
                    phase_d = phase_inc;
                end
            end
            StDrain: begin
                if (!col_any) begin
                    state_d = StDone;
                end else if (timeout) begin
                    state_d = StAbort;
                end else begin
                    phase_d = phase_inc;
                end
            end
            StDone, StAbort: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    always_comb begin
        mm_ready   = grant_mm;
        bist_ready = grant_bist;
        start_fsm  = 1'b0;
        bist_mode  = 1'b0;
        array_rst  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        done_owner = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            busy       = (state_q != StIdle);
            start_fsm  = (state_q == StStart);
            done       = (state_q == StDone);
            err        = (state_q == StAbort);
            array_rst  = (state_q == StAbort);
            bist_mode  = busy && (owner_q == OWN_BIST);
            done_owner = (done || err) && (owner_q == OWN_BIST);
        end
    end

endmodule

// File: doc/systolic_job_arbiter.md
SYSTOLIC_JOB_ARBITER -- requirements
Module: systolic_job_arbiter

Interface
REQ-001 SHALL have parameter ROWS, default 4, systolic array row count.
REQ-002 SHALL have parameter COLS, default 4, systolic array column count.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles per job phase before abort.
REQ-004 SHALL have parameter STARVE_LIMIT, default 2, max consecutive matmul grants while a BIST request is pending.
REQ-005 SHALL use a single clock and synchronous active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port mm_valid  input  1  matmul job request.
REQ-007 SHALL have port mm_ready  output  1  matmul request accepted; one-cycle pulse.
REQ-008 SHALL have port bist_valid  input  1  BIST job request.
REQ-009 SHALL have port bist_ready  output  1  BIST request accepted; one-cycle pulse.
REQ-010 SHALL have port start_fsm  output  1  one-cycle start pulse to the array sequencer.
REQ-011 SHALL have port bist_mode  output  1  array in test mode; held for the whole BIST job.
REQ-012 SHALL have port output_col_valid  input  COLS  per-column valid flags from the array sequencer.
REQ-013 SHALL have port array_rst  output  1  one-cycle reset pulse to the array sequencer on abort.
REQ-014 SHALL have port busy  output  1  job in flight; high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle job-completion pulse.
REQ-016 SHALL have port done_owner  output  1  owner of the completed or aborted job (0 matmul, 1 BIST); valid with done or err.
REQ-017 SHALL have port err  output  1  one-cycle timeout-abort pulse.

Function
REQ-018 SHALL implement the states IDLE, START, WAIT_OUT, DRAIN, DONE and ABORT.
REQ-019 In IDLE with any valid input, SHALL grant that cycle: assert the ready of the winner, latch the owner, and go to START.
REQ-020 SHALL grant matmul when both requests are valid, unless the defer counter equals STARVE_LIMIT, in which case BIST wins.
REQ-021 SHALL increment the defer counter on each matmul grant while bist_valid is high, and clear it on every BIST grant.
REQ-022 In START, SHALL pulse start_fsm for one cycle, clear the phase counter, and go to WAIT_OUT.
REQ-023 In WAIT_OUT, SHALL go to DRAIN when output_col_valid is nonzero.
REQ-024 In WAIT_OUT, SHALL go to ABORT when the phase counter reaches TIMEOUT-1.
REQ-025 In DRAIN, SHALL go to DONE when output_col_valid equals zero, and to ABORT on timeout; the phase counter restarts on DRAIN entry.
REQ-026 In DONE, SHALL pulse done with done_owner for one cycle and return to IDLE; a new grant is possible at the earliest in the cycle after DONE.
REQ-027 In ABORT, SHALL pulse err and array_rst for one cycle, set done_owner, and return to IDLE.
REQ-028 SHALL hold bist_mode equal to the latched owner from START through DONE or ABORT, and drive it 0 in IDLE.
REQ-029 SHALL keep both ready outputs 0 outside IDLE; a request arriving while busy remains pending.
REQ-030 SHALL size the phase counter to clog2(TIMEOUT)+1 bits and never let it wrap.
REQ-031 SHALL size the defer counter to clog2(STARVE_LIMIT)+1 bits and saturate it at STARVE_LIMIT.
REQ-032 SHALL treat output_col_valid nonzero already in the START cycle as seen, so the first WAIT_OUT cycle goes to DRAIN.

Reset
REQ-033 On rst, SHALL enter IDLE and clear the owner, defer counter and phase counter.
REQ-034 On rst, SHALL drive all outputs to 0.
REQ-035 SHALL honour rst in any state, including mid-job, with no done or err pulse.

Structure
REQ-036 SHALL take the state enum and owner encoding (OWN_MM=0, OWN_BIST=1) from a shared package, systolic_ctrl_pkg.
REQ-037 SHALL take ROWS and COLS from the existing header defines.
REQ-038 SHALL implement arbitration as one sub-module, job_priority_sel (combinational winner selection plus defer counter).

Verification
REQ-039 Matmul only: mm_valid=1 at cycle 0, output_col_valid=4'b0001 at cycle 5, 0 at cycle 12 -> mm_ready@0, start_fsm@1, done@13 with done_owner=0.
REQ-040 Contention: both valid continuously -> grant sequence MM, MM, BIST, MM, MM, BIST; bist_ready only on every third grant.
REQ-041 Timeout: matmul granted, output_col_valid stays 0 -> err and array_rst pulse exactly 64 cycles after start_fsm, then IDLE.
REQ-042 Stuck drain: output_col_valid held 4'b1111 -> err 64 cycles after DRAIN entry, done never pulses.
REQ-043 Reset mid-job: rst asserted during DRAIN -> next cycle busy=0, bist_mode=0, no done or err, defer counter 0.
REQ-044 BIST job: bist_valid only -> bist_mode=1 from START until the DONE cycle, done_owner=1.
